// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer port bundle: video fetch, host access and the shared BRAM port.
// master = requesters plus BRAM, slave = the arbiter.
interface fb_port_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 16
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;

    modport master (
        output vid_req, vid_addr,
        output host_req, host_we, host_addr, host_wdata,
        output bram_rdata,
        input  vid_rvalid, vid_rdata,
        input  host_ack, host_rvalid, host_rdata,
        input  bram_en, bram_we, bram_addr, bram_wdata
    );

    modport slave (
        input  vid_req, vid_addr,
        input  host_req, host_we, host_addr, host_wdata,
        input  bram_rdata,
        output vid_rvalid, vid_rdata,
        output host_ack, host_rvalid, host_rdata,
        output bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: video has fixed priority, the host gets a
// forced slot after MAX_WAIT denied cycles, read data is steered by a tag.
module fb_port_arbiter #(
    parameter int AW       = 19,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    fb_port_arbiter_if.slave  bus,
    output logic [7:0]        vid_miss_cnt
);
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_HOST
    } rd_tag_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    rd_tag_t       rd_tag;
    logic [7:0]    wait_cnt;
    logic          force_host;
    logic          grant_vid;
    logic          grant_host;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_wdata;

    always_comb begin
        force_host  = bus.host_req && (wait_cnt == WAIT_LIM);
        grant_vid   = !RESET && bus.vid_req && !force_host;
        grant_host  = !RESET && bus.host_req && (!bus.vid_req || force_host);
        grant_addr  = '0;
        grant_wdata = '0;
        // Unused address/data lines are parked at zero when the port is idle.
        if (grant_host) begin
            grant_addr  = bus.host_addr;
            grant_wdata = bus.host_wdata;
        end else if (grant_vid) begin
            grant_addr  = bus.vid_addr;
        end
    end

    assign bus.bram_en     = grant_vid || grant_host;
    assign bus.bram_we     = grant_host && bus.host_we;
    assign bus.bram_addr   = grant_addr;
    assign bus.bram_wdata  = grant_wdata;
    assign bus.host_ack    = grant_host;

    assign bus.vid_rvalid  = (rd_tag == TAG_VID);
    assign bus.host_rvalid = (rd_tag == TAG_HOST);
    assign bus.vid_rdata   = bus.bram_rdata;
    assign bus.host_rdata  = bus.bram_rdata;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt     <= '0;
            rd_tag       <= TAG_NONE;
            vid_miss_cnt <= '0;
        end else begin
            if (!bus.host_req || grant_host)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_LIM)
                wait_cnt <= wait_cnt + 8'd1;

            if (grant_vid)
                rd_tag <= TAG_VID;
            else if (grant_host && !bus.host_we)
                rd_tag <= TAG_HOST;
            else
                rd_tag <= TAG_NONE;

            // A host grant while video is requesting can only be a forced one.
            if (grant_host && bus.vid_req && (vid_miss_cnt != 8'hFF))
                vid_miss_cnt <= vid_miss_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed scenarios plus randomized
// traffic against a rule-level reference model and a behavioural BRAM.
module tb_fb_port_arbiter;
    localparam int AW       = 19;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 8;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] vid_miss_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    fb_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    fb_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .bus          (bus),
        .vid_miss_cnt (vid_miss_cnt)
    );

    always #5 CLK = ~CLK;

    // Behavioural BRAM, preloaded with the pattern data = addr[15:0].
    logic [DW-1:0] bram_mem [int];
    always @(posedge CLK) begin
        if (bus.bram_en === 1'b1) begin
            if (bus.bram_we === 1'b1)
                bram_mem[int'(bus.bram_addr)] = bus.bram_wdata;
            else if (bram_mem.exists(int'(bus.bram_addr)))
                bus.bram_rdata <= bram_mem[int'(bus.bram_addr)];
            else
                bus.bram_rdata <= bus.bram_addr[15:0];
        end
    end

    // Reference model: 0 = no grant, 1 = video, 2 = host.
    logic [DW-1:0] ref_mem [int];
    int            m_wait = 0;
    int            m_tag  = 0;
    int            m_miss = 0;
    logic [DW-1:0] m_rdata = '0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return a[15:0];
    endfunction

    function automatic int exp_grant();
        if (RESET) return 0;
        if (bus.host_req && m_wait >= MAX_WAIT) return 2;
        if (bus.vid_req) return 1;
        if (bus.host_req) return 2;
        return 0;
    endfunction

    task automatic model_advance(input int g);
        if (RESET) begin
            m_wait = 0; m_tag = 0; m_miss = 0;
            return;
        end
        if (g == 2 && bus.vid_req && m_miss < 255) m_miss++;
        if (!bus.host_req || g == 2) m_wait = 0;
        else m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        m_tag = 0;
        if (g == 1) begin
            m_tag = 1; m_rdata = ref_rd(bus.vid_addr);
        end else if (g == 2) begin
            if (bus.host_we) ref_mem[int'(bus.host_addr)] = bus.host_wdata;
            else begin m_tag = 2; m_rdata = ref_rd(bus.host_addr); end
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic v, input logic [AW-1:0] va,
                         input logic h, input logic we, input logic [AW-1:0] ha,
                         input logic [DW-1:0] wd);
        @(negedge CLK);
        RESET = r;
        bus.vid_req = v; bus.vid_addr = va;
        bus.host_req = h; bus.host_we = we; bus.host_addr = ha; bus.host_wdata = wd;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, AW'(5), 1, 0, AW'(7), '0);
            n_cmp++; if (bus.bram_en !== 1'b0) begin n_bad++; $display("FAIL rst_en got=%b exp=0", bus.bram_en); end
            n_cmp++; if (bus.host_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack got=%b exp=0", bus.host_ack); end
            n_cmp++; if (bus.vid_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0) begin
                n_bad++; $display("FAIL rst_rvalid got=%b%b exp=00", bus.vid_rvalid, bus.host_rvalid); end
            n_cmp++; if (vid_miss_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_miss got=%0d exp=0", vid_miss_cnt); end
            model_advance(exp_grant());
        end
    endtask

    task automatic test_video_only();
        for (int i = 0; i < 640; i++) begin
            drive(0, 1, AW'(i), 0, 0, '0, '0);
            n_cmp++; if (bus.bram_en !== 1'b1 || bus.bram_we !== 1'b0 || bus.bram_addr !== AW'(i)) begin
                n_bad++; $display("FAIL vid_port i=%0d got en=%b we=%b addr=%h exp 1/0/%h", i, bus.bram_en, bus.bram_we, bus.bram_addr, i); end
            n_cmp++; if (bus.host_ack !== 1'b0) begin n_bad++; $display("FAIL vid_ack i=%0d got=%b exp=0", i, bus.host_ack); end
            if (i > 0) begin
                n_cmp++; if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== DW'(i - 1) || bus.host_rvalid !== 1'b0) begin
                    n_bad++; $display("FAIL vid_data i=%0d got v=%b d=%h hv=%b exp 1/%h/0", i, bus.vid_rvalid, bus.vid_rdata, bus.host_rvalid, i - 1); end
            end
            model_advance(exp_grant());
        end
        drive(0, 0, '0, 0, 0, '0, '0);
        n_cmp++; if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== 16'd639) begin
            n_bad++; $display("FAIL vid_last got v=%b d=%h exp 1/027f", bus.vid_rvalid, bus.vid_rdata); end
        n_cmp++; if (bus.bram_en !== 1'b0 || bus.bram_addr !== '0 || bus.bram_wdata !== '0) begin
            n_bad++; $display("FAIL idle_park got en=%b addr=%h wd=%h exp 0/0/0", bus.bram_en, bus.bram_addr, bus.bram_wdata); end
        model_advance(exp_grant());
    endtask

    task automatic test_host_idle_slot();
        drive(0, 0, '0, 1, 1, AW'('h100), 16'hF800);
        n_cmp++; if (bus.host_ack !== 1'b1 || bus.bram_we !== 1'b1 || bus.bram_addr !== AW'('h100) || bus.bram_wdata !== 16'hF800) begin
            n_bad++; $display("FAIL host_wr got ack=%b we=%b addr=%h wd=%h exp 1/1/100/f800", bus.host_ack, bus.bram_we, bus.bram_addr, bus.bram_wdata); end
        model_advance(exp_grant());
        drive(0, 0, '0, 1, 0, AW'('h100), '0);
        n_cmp++; if (bus.host_ack !== 1'b1 || bus.bram_we !== 1'b0) begin
            n_bad++; $display("FAIL host_rd_grant got ack=%b we=%b exp 1/0", bus.host_ack, bus.bram_we); end
        n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_bad++; $display("FAIL host_wr_norv got=%b exp=0", bus.host_rvalid); end
        model_advance(exp_grant());
        drive(0, 0, '0, 0, 0, '0, '0);
        n_cmp++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 16'hF800 || bus.vid_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL host_rd_data got v=%b d=%h vv=%b exp 1/f800/0", bus.host_rvalid, bus.host_rdata, bus.vid_rvalid); end
        model_advance(exp_grant());
    endtask

    task automatic test_starvation();
        int ack_cyc = -1;
        logic [AW-1:0] va;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            va = AW'($urandom_range(0, 639));
            drive(0, 1, va, 1, 0, AW'('h100), '0);
            if (bus.host_ack === 1'b1) begin
                ack_cyc = c;
                n_cmp++; if (bus.bram_addr !== AW'('h100) || bus.bram_we !== 1'b0) begin
                    n_bad++; $display("FAIL starve_force got addr=%h we=%b exp 100/0", bus.bram_addr, bus.bram_we); end
            end else begin
                n_cmp++; if (bus.bram_addr !== va) begin
                    n_bad++; $display("FAIL starve_vid c=%0d got=%h exp=%h", c, bus.bram_addr, va); end
            end
            model_advance(exp_grant());
        end
        n_cmp++; if (ack_cyc != MAX_WAIT + 1) begin
            n_bad++; $display("FAIL starve_cycle got=%0d exp=%0d", ack_cyc, MAX_WAIT + 1); end
        va = AW'($urandom_range(0, 639));
        drive(0, 1, va, 0, 0, '0, '0);
        n_cmp++; if (vid_miss_cnt !== 8'd1) begin n_bad++; $display("FAIL starve_miss got=%0d exp=1", vid_miss_cnt); end
        n_cmp++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 16'hF800 || bus.vid_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL starve_rdata got v=%b d=%h vv=%b exp 1/f800/0", bus.host_rvalid, bus.host_rdata, bus.vid_rvalid); end
        n_cmp++; if (bus.bram_en !== 1'b1 || bus.bram_addr !== va || bus.host_ack !== 1'b0) begin
            n_bad++; $display("FAIL starve_resume got en=%b addr=%h ack=%b exp 1/%h/0", bus.bram_en, bus.bram_addr, bus.host_ack, va); end
        model_advance(exp_grant());
    endtask

    task automatic test_saturation();
        int acks = 0;
        int g;
        for (int c = 0; c < 4000 && acks < 300; c++) begin
            drive(0, 1, AW'($urandom_range(0, 639)), 1, 0, AW'('h100), '0);
            g = exp_grant();
            n_cmp++; if (bus.host_ack !== (g == 2)) begin
                n_bad++; $display("FAIL sat_ack c=%0d got=%b exp=%b", c, bus.host_ack, g == 2); end
            n_cmp++; if (vid_miss_cnt !== 8'(m_miss)) begin
                n_bad++; $display("FAIL sat_miss c=%0d got=%0d exp=%0d", c, vid_miss_cnt, m_miss); end
            if (bus.host_ack === 1'b1) acks++;
            model_advance(g);
        end
        n_cmp++; if (acks != 300) begin n_bad++; $display("FAIL sat_acks got=%0d exp=300", acks); end
        drive(0, 0, '0, 0, 0, '0, '0);
        n_cmp++; if (vid_miss_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_final got=%0d exp=255", vid_miss_cnt); end
        model_advance(exp_grant());
    endtask

    task automatic test_tagging();
        drive(0, 1, AW'('h20), 0, 0, '0, '0);
        model_advance(exp_grant());
        drive(0, 0, '0, 1, 1, AW'('h21), 16'h1234);
        n_cmp++; if (bus.vid_rvalid !== 1'b1 || bus.host_rvalid !== 1'b0 || bus.vid_rdata !== 16'h0020) begin
            n_bad++; $display("FAIL tag_vid got vv=%b hv=%b d=%h exp 1/0/0020", bus.vid_rvalid, bus.host_rvalid, bus.vid_rdata); end
        model_advance(exp_grant());
        drive(0, 0, '0, 1, 0, AW'('h21), '0);
        n_cmp++; if (bus.vid_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL tag_wr got vv=%b hv=%b exp 0/0", bus.vid_rvalid, bus.host_rvalid); end
        model_advance(exp_grant());
        drive(0, 1, AW'('h21), 0, 0, '0, '0);
        n_cmp++; if (bus.host_rvalid !== 1'b1 || bus.vid_rvalid !== 1'b0 || bus.host_rdata !== 16'h1234) begin
            n_bad++; $display("FAIL tag_host got hv=%b vv=%b d=%h exp 1/0/1234", bus.host_rvalid, bus.vid_rvalid, bus.host_rdata); end
        model_advance(exp_grant());
        drive(0, 0, '0, 0, 0, '0, '0);
        n_cmp++; if (bus.vid_rvalid !== 1'b1 || bus.host_rvalid !== 1'b0 || bus.vid_rdata !== 16'h1234) begin
            n_bad++; $display("FAIL tag_wr_then_vid got vv=%b hv=%b d=%h exp 1/0/1234", bus.vid_rvalid, bus.host_rvalid, bus.vid_rdata); end
        model_advance(exp_grant());
    endtask

    task automatic test_reset_mid();
        drive(0, 1, AW'('h30), 0, 0, '0, '0);
        n_cmp++; if (bus.bram_en !== 1'b1) begin n_bad++; $display("FAIL rm_grant got=%b exp=1", bus.bram_en); end
        #2 RESET = 1'b1;
        #1;
        n_cmp++; if (bus.bram_en !== 1'b0 || bus.host_ack !== 1'b0) begin
            n_bad++; $display("FAIL rm_suppress got en=%b ack=%b exp 0/0", bus.bram_en, bus.host_ack); end
        model_advance(exp_grant());
        drive(1, 1, AW'('h31), 1, 0, AW'('h5), '0);
        n_cmp++; if (bus.vid_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0 || vid_miss_cnt !== 8'd0) begin
            n_bad++; $display("FAIL rm_cleared got vv=%b hv=%b miss=%0d exp 0/0/0", bus.vid_rvalid, bus.host_rvalid, vid_miss_cnt); end
        n_cmp++; if (bus.bram_en !== 1'b0 || bus.host_ack !== 1'b0 || bus.bram_addr !== '0) begin
            n_bad++; $display("FAIL rm_held got en=%b ack=%b addr=%h exp 0/0/0", bus.bram_en, bus.host_ack, bus.bram_addr); end
        model_advance(exp_grant());
        drive(0, 1, AW'('h32), 0, 0, '0, '0);
        n_cmp++; if (bus.bram_en !== 1'b1 || bus.bram_addr !== AW'('h32) || bus.vid_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL rm_resume got en=%b addr=%h vv=%b exp 1/32/0", bus.bram_en, bus.bram_addr, bus.vid_rvalid); end
        model_advance(exp_grant());
        drive(1, 0, '0, 0, 0, '0, '0);
        n_cmp++; if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== 16'h0032) begin
            n_bad++; $display("FAIL rm_late_rv got v=%b d=%h exp 1/0032", bus.vid_rvalid, bus.vid_rdata); end
        model_advance(exp_grant());
        drive(0, 0, '0, 0, 0, '0, '0);
        n_cmp++; if (bus.vid_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_after got=%b exp=0", bus.vid_rvalid); end
        model_advance(exp_grant());
    endtask

    task automatic test_random_traffic();
        logic h = 1'b0, we = 1'b0, v, r;
        logic [AW-1:0] ha = '0, va, e_addr;
        logic [DW-1:0] wd = '0, e_wd;
        int g, vprob;
        for (int c = 0; c < 3000; c++) begin
            vprob = ((c / 500) % 2 == 1) ? 95 : 40;
            if (!h) begin
                h  = ($urandom_range(0, 99) < 50);
                we = 1'($urandom_range(0, 1));
                ha = AW'($urandom_range(0, 31));
                wd = DW'($urandom);
            end
            v  = ($urandom_range(0, 99) < vprob);
            va = AW'($urandom_range(0, 31));
            r  = ($urandom_range(0, 199) == 0);
            drive(r, v, va, h, we, ha, wd);
            g      = exp_grant();
            e_addr = (g == 2) ? ha : (g == 1) ? va : '0;
            e_wd   = (g == 2) ? wd : '0;
            n_cmp++; if (bus.bram_en !== (g != 0) || bus.bram_we !== (g == 2 && we) || bus.host_ack !== (g == 2)) begin
                n_bad++; $display("FAIL rnd_ctl c=%0d got en=%b we=%b ack=%b exp %b/%b/%b", c,
                    bus.bram_en, bus.bram_we, bus.host_ack, g != 0, g == 2 && we, g == 2); end
            n_cmp++; if (bus.bram_addr !== e_addr || bus.bram_wdata !== e_wd) begin
                n_bad++; $display("FAIL rnd_bus c=%0d got addr=%h wd=%h exp %h/%h", c, bus.bram_addr, bus.bram_wdata, e_addr, e_wd); end
            n_cmp++; if (bus.vid_rvalid !== (m_tag == 1) || bus.host_rvalid !== (m_tag == 2)) begin
                n_bad++; $display("FAIL rnd_rv c=%0d got vv=%b hv=%b exp tag=%0d", c, bus.vid_rvalid, bus.host_rvalid, m_tag); end
            if (m_tag == 1) begin
                n_cmp++; if (bus.vid_rdata !== m_rdata) begin
                    n_bad++; $display("FAIL rnd_vdata c=%0d got=%h exp=%h", c, bus.vid_rdata, m_rdata); end
            end
            if (m_tag == 2) begin
                n_cmp++; if (bus.host_rdata !== m_rdata) begin
                    n_bad++; $display("FAIL rnd_hdata c=%0d got=%h exp=%h", c, bus.host_rdata, m_rdata); end
            end
            n_cmp++; if (vid_miss_cnt !== 8'(m_miss)) begin
                n_bad++; $display("FAIL rnd_miss c=%0d got=%0d exp=%0d", c, vid_miss_cnt, m_miss); end
            model_advance(g);
            if (g == 2) h = 1'b0;
        end
    endtask

    initial begin
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        test_reset();
        test_video_only();
        test_host_idle_slot();
        test_starvation();
        test_saturation();
        test_tagging();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port frame-buffer BRAM (1-cycle registered read) between two requesters.
- Requester 1 is the video scan-out fetch path, driven by the line/pixel address counters.
- Requester 2 is a host port that loads and inspects pixels.
- Video has fixed priority. A starvation guard forces one host slot after MAX_WAIT consecutive denied cycles. Read data is returned to its owner with a registered tag.

Parameters:
- AW, 19, BRAM word address width (640*480 = 307200 words)
- DW, 16, data width (RGB565)
- MAX_WAIT, 8, consecutive denied host cycles before a forced host grant (legal range 1..255)

Ports:
- CLK  in  1  system/pixel clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- vid_req  in  1  video read request, single-cycle, not held
- vid_addr  in  AW  video read address
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  DW  video read data
- host_req  in  1  host request; held with host_we/addr/wdata until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_ack  out  1  host granted this cycle (combinational)
- host_rvalid  out  1  host read data valid
- host_rdata  out  DW  host read data
- bram_en  out  1  BRAM enable (combinational)
- bram_we  out  1  BRAM write enable (combinational)
- bram_addr  out  AW  BRAM address (combinational)
- bram_wdata  out  DW  BRAM write data (combinational)
- bram_rdata  in  DW  BRAM read data, valid one cycle after an enabled read
- vid_miss_cnt  out  8  count of dropped video requests, saturating at 255

Behaviour:
- Reset values: wait_cnt = 0, rd_tag = NONE, vid_rvalid = 0, host_rvalid = 0, vid_miss_cnt = 0.
- While RESET is high, all grants are suppressed: bram_en = 0, host_ack = 0.
- Arbitration, evaluated combinationally each cycle; at most one grant per cycle:
  - force = host_req && (wait_cnt == MAX_WAIT).
  - GRANT_VID: vid_req && !force. Drives bram_en=1, bram_we=0, bram_addr=vid_addr.
  - GRANT_HOST: host_req && (!vid_req || force). Drives bram_en=1, bram_we=host_we, bram_addr=host_addr, bram_wdata=host_wdata, host_ack=1.
  - IDLE: no grant. Drives bram_en=0, bram_we=0. bram_addr and bram_wdata are don't-care but must be held at 0.
- wait_cnt (registered):
  - Cleared on any host grant and whenever host_req is low.
  - Otherwise incremented while host_req is high and the host is denied.
  - Never exceeds MAX_WAIT.
- Forced host grant with vid_req high:
  - The video request is dropped; no retry.
  - vid_miss_cnt increments by 1 and holds at 255.
- Read return tag (registered rd_tag ∈ {NONE, VID, HOST}):
  - Set to VID on a video grant.
  - Set to HOST on a host grant with host_we = 0.
  - Set to NONE otherwise, including host writes.
  - vid_rvalid = (rd_tag == VID) and host_rvalid = (rd_tag == HOST), both registered.
  - vid_rdata and host_rdata both pass through bram_rdata; they are meaningful only while the matching valid is high.
- Latency: grant in cycle N -> rvalid and data in cycle N+1. Back-to-back grants give one valid per cycle with no bubble.
- Host handshake:
  - host_ack is 1 in the grant cycle only.
  - The host may drop or change its request in the cycle after ack.
  - A new host request may be granted in the cycle immediately after ack.
- Simultaneous events:
  - vid_req and host_req together with wait_cnt < MAX_WAIT: the video wins and wait_cnt increments.
  - Host write followed by a video read of the same address: the video read returns the new data (BRAM write-first is not required, because the accesses are in different cycles).
- Reset mid-operation: a grant issued in the cycle before RESET still produces its rvalid if RESET is sampled afterward. If RESET is high in the edge following the grant, rd_tag is cleared and no rvalid is produced.
- Width rules: no address arithmetic is performed; vid_miss_cnt is an 8-bit saturating counter.

Test Plan:
- Video only: vid_req every cycle, addr 0..639 -> bram_addr follows addr in the same cycle; vid_rvalid=1 from cycle 1 onward; vid_rdata = preloaded pattern addr[15:0]; host_ack never asserted.
- Host idle-slot: host write addr 0x100 data 0xF800 with vid_req low -> host_ack in the same cycle, bram_we=1. Host read 0x100 next -> host_rvalid one cycle later, host_rdata = 0xF800.
- Starvation: vid_req held high, host read pending, MAX_WAIT=8 -> host_ack on the 9th cycle; vid_miss_cnt=1; wait_cnt back to 0; video grants resume the next cycle.
- Saturation: force 300 starved host grants under continuous vid_req -> vid_miss_cnt stops at 255.
- Tagging: alternate video read / host write / host read grants -> only the matching rvalid is asserted at N+1; no rvalid follows the host write.
- Reset mid-operation: assert RESET in the edge after a video grant -> no vid_rvalid; all outputs at reset values; normal arbitration resumes the cycle after RESET deasserts.
